// File: rtl/tcam_lookup_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tcam_lookup_arbiter_pkg
// Shared definitions for the TCAM lookup arbiter:
//   - default parameter values (requesters, key width, tag depth, index width)
//   - tag_width(): width of a requester id tag, clog2(NREQ), at least 1 bit
//   - tcam_result_t: action-stage result {hit, index}
// ---------------------------------------------------------------------------
package tcam_lookup_arbiter_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int KEY_W_DEF     = 32;
  localparam int TAG_DEPTH_DEF = 4;
  localparam int IDX_W_DEF     = 4;

  typedef struct packed {
    logic                 hit;
    logic [IDX_W_DEF-1:0] index;
  } tcam_result_t;

  // Requester-id tag width; a single requester still needs one bit of storage.
  function automatic int tag_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/tcam_tag_fifo.sv
// ---------------------------------------------------------------------------
// tcam_tag_fifo
// Synchronous in-order FIFO holding the requester id of every lookup that
// the TCAM stage has accepted but whose result has not yet been returned.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_data   write one tag (ignored when full)
//   i_pop            discard the head tag (ignored when empty)
//   o_data           head tag (valid while !o_empty)
//   o_count          occupancy, one bit wider than the pointers
//   o_full, o_empty  status flags derived from o_count
// ---------------------------------------------------------------------------
module tcam_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == {(PW+1){1'b0}});
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Tag storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {(PW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tcam_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// tcam_lookup_arbiter
// Shares one TCAM lookup pipeline between NREQ requesters. Keys are granted
// round-robin onto the lk_valid/lk_ready handshake; the id of each accepted
// lookup is queued in an in-order tag FIFO, and each action-stage result is
// steered combinationally back to the requester at the FIFO head.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_req_valid/i_req_key/o_req_ready  per-requester key handshake
//   o_lk_valid/o_lk_key/i_lk_ready     key handshake to the TCAM stage
//   i_res_valid/i_res_hit/i_res_index/o_res_ready  action-stage result
//   o_rsp_valid/o_rsp_hit/o_rsp_index/i_rsp_ready  per-requester result
//   o_inflight                     lookups outstanding (tag FIFO occupancy)
//   o_err_orphan                   sticky: result seen with nothing outstanding
// ---------------------------------------------------------------------------
module tcam_lookup_arbiter
  import tcam_lookup_arbiter_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NREQ-1:0]              i_req_valid,
  input  logic [NREQ*KEY_W-1:0]        i_req_key,
  output logic [NREQ-1:0]              o_req_ready,
  output logic                         o_lk_valid,
  output logic [KEY_W-1:0]             o_lk_key,
  input  logic                         i_lk_ready,
  input  logic                         i_res_valid,
  input  logic                         i_res_hit,
  input  logic [IDX_W-1:0]             i_res_index,
  output logic                         o_res_ready,
  output logic [NREQ-1:0]              o_rsp_valid,
  output logic                         o_rsp_hit,
  output logic [IDX_W-1:0]             o_rsp_index,
  input  logic [NREQ-1:0]              i_rsp_ready,
  output logic [$clog2(TAG_DEPTH):0]   o_inflight,
  output logic                         o_err_orphan
);

  localparam int TAG_W = tag_width(NREQ);

  logic [TAG_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [TAG_W-1:0] r_lock_id;
  logic             r_err_orphan;

  logic [TAG_W:0]   w_sum;
  logic [TAG_W-1:0] w_cand;
  logic             w_take;
  logic [TAG_W-1:0] w_search_id;
  logic             w_search_hit;
  logic [TAG_W-1:0] w_grant;
  logic [TAG_W-1:0] w_rr_next;
  logic             w_any;
  logic             w_accept;
  logic             w_pop;
  logic [TAG_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;

  // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... mod NREQ.
  always_comb begin
    w_sum        = {(TAG_W+1){1'b0}};
    w_cand       = {TAG_W{1'b0}};
    w_take       = 1'b0;
    w_search_id  = r_rr_ptr;
    w_search_hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum        = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
      w_sum        = (w_sum >= (TAG_W+1)'(NREQ)) ? (w_sum - (TAG_W+1)'(NREQ)) : w_sum;
      w_cand       = w_sum[TAG_W-1:0];
      w_take       = ~w_search_hit & i_req_valid[w_cand];
      w_search_id  = w_take ? w_cand : w_search_id;
      w_search_hit = w_search_hit | w_take;
    end
  end

  // A locked grant is held until the TCAM stage takes the key, so the
  // presented key never changes under backpressure.
  assign w_grant   = r_lock ? r_lock_id : w_search_id;
  assign w_any     = r_lock ? i_req_valid[r_lock_id] : w_search_hit;
  assign w_rr_next = (w_grant == TAG_W'(NREQ-1)) ? {TAG_W{1'b0}} : (w_grant + TAG_W'(1));

  // Full is the registered occupancy, so lk_valid never depends on res_valid.
  assign o_lk_valid  = i_rst_n & w_any & ~w_full;
  assign o_lk_key    = i_req_key[int'(w_grant)*KEY_W +: KEY_W];
  assign w_accept    = o_lk_valid & i_lk_ready;
  assign o_req_ready = w_accept ? (NREQ'(1) << w_grant) : {NREQ{1'b0}};

  // Results with nothing outstanding are always consumed and dropped.
  assign o_res_ready = i_rst_n & (w_empty | i_rsp_ready[w_head]);
  assign w_pop       = i_res_valid & o_res_ready & ~w_empty;
  assign o_rsp_hit   = i_res_hit;
  assign o_rsp_index = i_res_index;
  assign o_err_orphan = r_err_orphan;

  // Steer the result valid to the requester that issued the head lookup.
  always_comb begin
    o_rsp_valid = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      o_rsp_valid[i] = i_rst_n & i_res_valid & ~w_empty & (w_head == TAG_W'(i));
    end
  end

  tcam_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_accept),
    .i_data  (w_grant),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (o_inflight),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Arbiter state: round-robin pointer, grant lock, sticky orphan flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= {TAG_W{1'b0}};
      r_lock       <= 1'b0;
      r_lock_id    <= {TAG_W{1'b0}};
      r_err_orphan <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr_ptr  <= w_rr_next;
        r_lock    <= 1'b0;
        r_lock_id <= r_lock_id;
      end else if (o_lk_valid) begin
        r_rr_ptr  <= r_rr_ptr;
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end else begin
        r_rr_ptr  <= r_rr_ptr;
        r_lock    <= r_lock;
        r_lock_id <= r_lock_id;
      end
      if (i_res_valid && w_empty) begin
        r_err_orphan <= 1'b1;
      end else begin
        r_err_orphan <= r_err_orphan;
      end
    end
  end

endmodule
